// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field widths, opcode map and fetch state.
// Used by the fetch stage, the instruction ROMs and the decoder.
package cpu_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 9;
    localparam int OP_W   = 5;
    localparam int ARG_W  = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND   = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR    = 5'b00011;
    localparam logic [OP_W-1:0] OP_XOR   = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHL   = 5'b00101;
    localparam logic [OP_W-1:0] OP_SETI  = 5'b00110;
    localparam logic [OP_W-1:0] OP_LOAD  = 5'b00111;
    localparam logic [OP_W-1:0] OP_STORE = 5'b01000;
    localparam logic [OP_W-1:0] OP_JUMP  = 5'b01001;
    localparam logic [OP_W-1:0] OP_BEQ   = 5'b01010;
    localparam logic [OP_W-1:0] OP_BNE   = 5'b01011;
    localparam logic [OP_W-1:0] OP_HALT  = 5'b11010;
    localparam logic [OP_W-1:0] OP_TBD   = 5'b11011;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, samples the ROM word into the IF/ID
// register, and handles stall, redirect-with-squash and halt detection.
module inst_fetch #(
    parameter int                PC_W     = 16,
    parameter int                INST_W   = 9,
    parameter logic [PC_W-1:0]   RESET_PC = PC_W'(1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] instruction,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    output logic              if_valid,
    output logic              halted,
    output logic [15:0]       fetch_cnt
);
    import cpu_pkg::OP_W;
    import cpu_pkg::OP_HALT;
    import cpu_pkg::fetch_state_e;
    import cpu_pkg::RUN;
    import cpu_pkg::HALTED;

    fetch_state_e state;
    logic         is_halt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign is_halt = (instruction[INST_W-1 -: OP_W] == OP_HALT);

    // IF/ID register boundary: redirect beats stall, HALTED ignores stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pc        <= RESET_PC;
            if_inst   <= '0;
            if_pc     <= '0;
            if_valid  <= 1'b0;
            halted    <= 1'b0;
            fetch_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
            state    <= RUN;
            halted   <= 1'b0;
        end else if (state == HALTED) begin
            if_valid <= 1'b0;
        end else if (!stall) begin
            if_inst   <= instruction;
            if_pc     <= pc;
            if_valid  <= 1'b1;
            fetch_cnt <= sat_inc(fetch_cnt);
            if (is_halt) begin
                state  <= HALTED;
                halted <= 1'b1;
            end else begin
                pc <= pc + PC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a per-edge scoreboard of IF/ID contents.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [8:0]  instruction;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [8:0]  if_inst;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        halted;
    logic [15:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        v;
        logic [8:0]  inst;
        logic [15:0] ipc;
    } exp_t;

    exp_t        sb[$];
    logic [8:0]  rom [0:31];
    logic        long_run = 1'b0;
    logic [15:0] cur_pc;
    logic [15:0] exp_ipc;
    logic [8:0]  exp_inst;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .instruction    (instruction),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted),
        .fetch_cnt      (fetch_cnt)
    );

    function automatic logic [8:0] rom_word(input logic [15:0] a);
        if (long_run || a > 16'd31) return 9'h060;
        return rom[a[4:0]];
    endfunction

    always_comb instruction = rom_word(pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // One clock edge: push the expected IF/ID contents, then pop and compare after the edge.
    task automatic step(input logic st, input logic rv, input logic [15:0] rpc,
                        input logic [15:0] exp_pc, input logic exp_v, input logic exp_halt);
        exp_t e;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (exp_v && !st) begin
            exp_ipc  = cur_pc;
            exp_inst = rom_word(cur_pc);
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        sb.push_back('{v: exp_v, inst: exp_inst, ipc: exp_ipc});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("if_valid", 32'(if_valid), 32'(e.v));
            chk("if_inst", 32'(if_inst), 32'(e.inst));
            chk("if_pc", 32'(if_pc), 32'(e.ipc));
        end
        chk("pc", 32'(pc), 32'(exp_pc));
        chk("halted", 32'(halted), 32'(exp_halt));
        chk("fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
        cur_pc = exp_pc;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        chk("rst_pc", 32'(pc), 32'd1);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_inst", 32'(if_inst), 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
        rst      = 1'b0;
        cur_pc   = 16'd1;
        exp_ipc  = 16'd0;
        exp_inst = 9'd0;
        exp_cnt  = 16'd0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'd0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = {5'(i % 8), 4'(i)};
        rom[1]  = 9'h060;
        rom[14] = 9'h1A0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'd0;

        // Reset and first fetch
        do_reset(2);
        step(0, 0, 0, 16'd2, 1, 0);
        chk("first_inst", 32'(if_inst), 32'h060);
        step(0, 0, 0, 16'd3, 1, 0);
        step(0, 0, 0, 16'd4, 1, 0);
        step(0, 0, 0, 16'd5, 1, 0);

        // Stall three cycles at pc 5, then resume
        repeat (3) step(1, 0, 0, 16'd5, 1, 0);
        step(0, 0, 0, 16'd6, 1, 0);
        chk("resume_pc5", 32'(if_pc), 32'd5);
        step(0, 0, 0, 16'd7, 1, 0);

        // Redirect with stall at pc 7 -> target 3
        step(1, 1, 16'd3, 16'd3, 0, 0);
        step(0, 0, 0, 16'd4, 1, 0);
        chk("redir_target", 32'(if_pc), 32'd3);

        // Run to the halt word at 14
        for (int a = 5; a <= 14; a++) step(0, 0, 0, 16'(a), 1, 0);
        step(0, 0, 0, 16'd14, 1, 1);
        chk("halt_word", 32'(if_inst), 32'h1A0);
        step(0, 0, 0, 16'd14, 0, 1);
        step(1, 0, 0, 16'd14, 0, 1);
        step(0, 0, 0, 16'd14, 0, 1);

        // Redirect out of HALTED
        step(0, 1, 16'd2, 16'd2, 0, 0);
        for (int a = 3; a <= 14; a++) step(0, 0, 0, 16'(a), 1, 0);

        // Redirect coinciding with the halt fetch: halt never entered
        step(0, 1, 16'd20, 16'd20, 0, 0);
        step(0, 0, 0, 16'd21, 1, 0);
        chk("post_cancel_pc", 32'(if_pc), 32'd20);

        // PC wrap
        step(0, 1, 16'hFFFF, 16'hFFFF, 0, 0);
        step(0, 0, 0, 16'h0000, 1, 0);
        chk("wrap_if_pc", 32'(if_pc), 32'hFFFF);
        step(0, 0, 0, 16'h0001, 1, 0);

        // Reset mid-operation beats redirect and stall
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        do_reset(1);

        // Saturation: fetch past 65535 deliveries
        long_run = 1'b1;
        for (int k = 0; k < 65540; k++) step(0, 0, 0, cur_pc + 16'd1, 1, 0);
        chk("cnt_saturated", 32'(fetch_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

- Instruction fetch stage at the requesting end of the instruction-ROM interface.
- Owns the program counter and drives `pc` to the combinational instruction ROM. It samples the returned 9-bit instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with squash, and halt detection.
- Sits between the instruction ROM and the decode stage of the pipelined CPU.

## Interface

Parameters:
- `PC_W`, 16, program counter width
- `INST_W`, 9, instruction width ({opcode[8:4], arg[3:0]})
- `RESET_PC`, 1, first fetch address after reset (programs start at address 1)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc`  out  PC_W  fetch address to ROM (registered)
- `instruction`  in  INST_W  ROM data for `pc`, valid combinationally in the same cycle
- `stall`  in  1  decode not ready; hold `pc` and IF/ID register
- `redirect_valid`  in  1  taken branch/jump resolved downstream
- `redirect_pc`  in  PC_W  branch/jump target
- `if_inst`  out  INST_W  IF/ID instruction
- `if_pc`  out  PC_W  address of `if_inst`
- `if_valid`  out  1  `if_inst` is a live instruction
- `halted`  out  1  halt fetched; fetching stopped
- `fetch_cnt`  out  16  count of instructions delivered with `if_valid`=1, saturating at 0xFFFF

## Operation

- States: RUN, HALTED.
- Priority order each cycle: `rst` > `redirect_valid` > `stall` > normal fetch.
- RUN, normal:
  - `if_inst`<=`instruction`, `if_pc`<=`pc`, `if_valid`<=1
  - `pc`<=`pc`+1, wrapping 0xFFFF->0x0000
  - `fetch_cnt`++ (saturating)
- Halt detect: in RUN, no stall, no redirect, and `instruction[8:4]`==5'b11010:
  - the halt word is delivered normally (`if_valid`<=1)
  - `pc` is NOT incremented
  - state<=HALTED, `halted`<=1
- HALTED:
  - `pc` holds
  - `if_valid`<=0 every cycle (bubbles); `if_inst`/`if_pc` hold
  - `fetch_cnt` holds
  - `stall` is ignored
- Redirect (any state, overrides stall):
  - `pc`<=`redirect_pc`
  - `if_valid`<=0 (squash the word fetched this cycle)
  - `if_inst`/`if_pc` hold
  - state<=RUN, `halted`<=0. A speculatively fetched halt is cancelled by an older branch.
- Stall in RUN: `pc`, `if_inst`, `if_pc`, `if_valid`, `fetch_cnt` all hold.
- Opcodes other than halt are not interpreted. `jump` and branches resolve downstream and return via redirect.

## Timing

- Reset values:
  - `pc`=RESET_PC
  - `if_inst`=0, `if_pc`=0, `if_valid`=0
  - `halted`=0, `fetch_cnt`=0
  - state=RUN
- `rst` asserted mid-operation overrides redirect and stall in the same edge.
- Fetch latency: address on `pc` in cycle N. The word appears on `if_inst` with `if_valid`=1 after edge N+1.
- Throughput is 1 instruction/cycle with no stall.
- Redirect penalty: the word sampled on the redirect edge is squashed (1 bubble). The target word appears on `if_inst` one cycle after the redirect edge.
- `halted` rises on the same edge that delivers the halt word.
- Redirect in the same cycle as a halt fetch: redirect wins, halt is not entered, and the halt word is squashed.
- Stall and redirect together: redirect wins.

## Structure

Shared package `cpu_pkg`:
- opcode constants (5-bit `OP_ADD`..`OP_HALT`=5'b11010, `OP_TBD`=5'b11011)
- `INST_W`=9, `OP_W`=5, `ARG_W`=4
- `PC_W`=16

The ROM modules and the decoder use the same package.

Module layout:
- Single module. No sub-module is required.
- The state register may be a 1-bit enum {RUN, HALTED} from the package.

## Test plan

- **Reset:** hold `rst` 2 cycles, then release with the ROM returning `{seti,0000}` at pc 1 -> `pc`=1 during reset. Next edge gives `if_inst`=9'h060, `if_pc`=1, `if_valid`=1, `pc`=2.
- **Stall:** assert `stall` for 3 cycles at `pc`=5 -> `pc`, `if_inst`, `if_pc`, `fetch_cnt` unchanged for 3 edges. Fetch resumes at 5 on release.
- **Redirect:** at `pc`=7, pulse `redirect_valid` with `redirect_pc`=3, `stall`=1 -> next edge gives `pc`=3, `if_valid`=0. The following edge gives `if_pc`=3, `if_valid`=1.
- **Halt:** ROM returns `{halt,0000}` at pc 14 -> `if_inst`=9'h1A0, `if_pc`=14, `halted`=1, `pc` stays 14. `if_valid`=0 on all subsequent edges, `fetch_cnt` frozen.
- **Halt cancel:** redirect to 2 while halted -> `halted`=0, `pc`=2, normal fetch resumes. A redirect coinciding with the halt fetch never raises `halted`.
- **Wrap and saturation:** redirect to 0xFFFF -> `pc` goes 0xFFFF then 0x0000. Force `fetch_cnt` near 0xFFFF and keep fetching -> the count stays at 0xFFFF.
